// File: rtl/r16_pkg.sv
// Shared constants and sequencer state encoding for the radix-16 twiddle/data delay path.
package r16_pkg;

    localparam int unsigned D_WIDTH      = 64;
    localparam int unsigned R16_LANES    = 16;
    localparam int unsigned R16_WD_DELAY = 21;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_FIN   = 2'd3
    } seq_state_t;

endpackage

// File: rtl/r16_tag_pipe.sv
// Fixed-depth tag shift register that mirrors the data delay line; shifts every cycle.
module r16_tag_pipe
    import r16_pkg::*;
#(
    parameter int unsigned DELAY = R16_WD_DELAY,
    parameter int unsigned WIDTH = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] tag_i,
    output logic [WIDTH-1:0] tag_o
);

    logic [WIDTH-1:0] stage_q [DELAY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DELAY); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= tag_i;
            for (int i = 1; i < int'(DELAY); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_o = stage_q[DELAY-1];

endmodule

// File: rtl/r16_wd_seq_ctrl.sv
// Job sequencer: issues N source group reads and tags them through the delay line
// so the consumer sees valid/last/index aligned with the delayed data.
module r16_wd_seq_ctrl
    import r16_pkg::*;
#(
    parameter int unsigned DELAY  = R16_WD_DELAY,
    parameter int unsigned CNT_W  = 12,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_grp,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              src_avail,
    output logic              src_rd_en,
    output logic [ADDR_W-1:0] src_addr,
    output logic              out_valid,
    output logic              out_last,
    output logic [CNT_W-1:0]  out_grp_idx,
    output logic              busy,
    output logic              done,
    output logic              err_start
);

    localparam int unsigned TAG_W = CNT_W + 2;

    seq_state_t        state_q, state_d;
    logic [CNT_W-1:0]  num_q, num_d;
    logic [CNT_W-1:0]  issued_q, issued_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              busy_q, done_q, err_q;
    logic              rd_en_c, last_c;
    logic [TAG_W-1:0]  tag_in_c, tag_out;

    // Next-state, issue counter and combinational read strobe.
    always_comb begin
        state_d  = state_q;
        num_d    = num_q;
        issued_d = issued_q;
        base_d   = base_q;
        rd_en_c  = 1'b0;
        last_c   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (num_grp != CNT_W'(0)) begin
                        num_d    = num_grp;
                        base_d   = base_addr;
                        issued_d = CNT_W'(0);
                        state_d  = S_ISSUE;
                    end else begin
                        state_d  = S_FIN;
                    end
                end
            end
            S_ISSUE: begin
                if (src_avail) begin
                    rd_en_c  = 1'b1;
                    issued_d = issued_q + CNT_W'(1);
                    if (issued_q == num_q - CNT_W'(1)) begin
                        last_c  = 1'b1;
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (out_valid && out_last) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            num_q    <= '0;
            issued_q <= '0;
            base_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            num_q    <= num_d;
            issued_q <= issued_d;
            base_q   <= base_d;
            busy_q   <= (state_d == S_ISSUE) || (state_d == S_DRAIN);
            done_q   <= (state_d == S_FIN);
            err_q    <= start && (state_q != S_IDLE);
        end
    end

    // Index is zeroed on bubbles so out_grp_idx reads 0 whenever out_valid is low.
    assign tag_in_c = {rd_en_c, last_c, rd_en_c ? issued_q : CNT_W'(0)};

    r16_tag_pipe #(
        .DELAY (DELAY),
        .WIDTH (TAG_W)
    ) u_tag_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .tag_i (tag_in_c),
        .tag_o (tag_out)
    );

    assign src_rd_en   = rd_en_c;
    assign src_addr    = base_q + ADDR_W'(issued_q);
    assign out_valid   = tag_out[TAG_W-1];
    assign out_last    = tag_out[TAG_W-2];
    assign out_grp_idx = tag_out[CNT_W-1:0];
    assign busy        = busy_q;
    assign done        = done_q;
    assign err_start   = err_q;

endmodule

// File: tb/tb_r16_wd_seq_ctrl.sv
// Scoreboard bench for r16_wd_seq_ctrl: directed and random jobs against a cycle-stamped job model.
module tb_r16_wd_seq_ctrl;

    localparam int    DELAY = 21;
    localparam longint INF  = 64'h3fff_ffff_ffff_ffff;

    logic        clk, rst_n, start, src_avail;
    logic [11:0] num_grp;
    logic [9:0]  base_addr;
    logic        src_rd_en, out_valid, out_last, busy, done, err_start;
    logic [9:0]  src_addr;
    logic [11:0] out_grp_idx;

    r16_wd_seq_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .num_grp     (num_grp),
        .base_addr   (base_addr),
        .src_avail   (src_avail),
        .src_rd_en   (src_rd_en),
        .src_addr    (src_addr),
        .out_valid   (out_valid),
        .out_last    (out_last),
        .out_grp_idx (out_grp_idx),
        .busy        (busy),
        .done        (done),
        .err_start   (err_start)
    );

    always #5 clk = ~clk;

    int total, bad;
    longint cyc;

    typedef struct {
        longint cyc;
        int     idx;
        bit     last;
    } ev_t;

    ev_t    out_q[$];
    longint done_q[$];
    longint err_q[$];

    // Job model: which group is next, when the sequencer is free again, busy window.
    bit     issuing;
    int     m_n, m_k, m_base;
    longint free_from, busy_lo, busy_hi;
    bit     exp_rd;
    int     exp_addr;

    task automatic chk(input string name, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        out_q.delete();
        done_q.delete();
        err_q.delete();
        issuing   = 0;
        free_from = 0;
        busy_lo   = 1;
        busy_hi   = 0;
        m_k       = 0;
        m_n       = 0;
        m_base    = 0;
    endtask

    task automatic model_cycle(input bit st, input int n, input int b, input bit av);
        ev_t e;
        exp_rd = 0;
        if (issuing && av) begin
            exp_rd   = 1;
            exp_addr = (m_base + m_k) % 1024;
            e.cyc  = cyc + DELAY;
            e.idx  = m_k;
            e.last = (m_k == m_n - 1);
            out_q.push_back(e);
            if (m_k == m_n - 1) begin
                issuing   = 0;
                busy_hi   = cyc + DELAY;
                done_q.push_back(cyc + DELAY + 1);
                free_from = cyc + DELAY + 2;
            end
            m_k++;
        end
        if (st) begin
            if (!issuing && cyc >= free_from) begin
                if (n == 0) begin
                    done_q.push_back(cyc + 1);
                    free_from = cyc + 2;
                end else begin
                    issuing   = 1;
                    m_n       = n;
                    m_k       = 0;
                    m_base    = b;
                    busy_lo   = cyc + 1;
                    busy_hi   = INF;
                    free_from = INF;
                end
            end else begin
                err_q.push_back(cyc + 1);
            end
        end
    endtask

    // One clock cycle: entered and left at posedge+1.
    task automatic step(input bit st, input int n, input int b, input bit av);
        start     = st;
        num_grp   = 12'(n);
        base_addr = 10'(b);
        src_avail = av;
        model_cycle(st, n, b, av);
        @(negedge clk);
        chk("src_rd_en", longint'(src_rd_en), longint'(exp_rd));
        if (exp_rd) chk("src_addr", longint'(src_addr), longint'(exp_addr));
        chk("busy", longint'(busy), longint'(cyc >= busy_lo && cyc <= busy_hi));
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_job(input int n, input int b, input logic [15:0] pat, input int pat_len,
                           input int avail_pct, input int stray_pct, input bit poke_drain);
        int j, guard;
        bit av, st, poked;
        j = 0;
        guard = 0;
        poked = 0;
        step(1, n, b, 0);
        while ((issuing || cyc < free_from) && guard < 20000) begin
            av = (j < pat_len) ? pat[j] : (int'($urandom_range(99)) < avail_pct);
            st = (int'($urandom_range(99)) < stray_pct);
            if (poke_drain && !issuing && !poked) begin
                st    = 1;
                poked = 1;
            end
            step(st, int'($urandom_range(8)), int'($urandom_range(1023)), av);
            j++;
            guard++;
        end
        chk("job_timeout", longint'(guard >= 20000), 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd_en"}, longint'(src_rd_en), 0);
        chk({tag, "_addr"},  longint'(src_addr), 0);
        chk({tag, "_valid"}, longint'(out_valid), 0);
        chk({tag, "_last"},  longint'(out_last), 0);
        chk({tag, "_idx"},   longint'(out_grp_idx), 0);
        chk({tag, "_busy"},  longint'(busy), 0);
        chk({tag, "_done"},  longint'(done), 0);
        chk({tag, "_err"},   longint'(err_start), 0);
    endtask

    // Monitor: pops expected events whose cycle stamp matches the current cycle.
    always @(negedge clk) begin
        bit ev;
        if (rst_n) begin
            ev = (out_q.size() > 0) && (out_q[0].cyc == cyc);
            chk("out_valid", longint'(out_valid), longint'(ev));
            if (ev) begin
                chk("out_grp_idx", longint'(out_grp_idx), longint'(out_q[0].idx));
                chk("out_last", longint'(out_last), longint'(out_q[0].last));
                void'(out_q.pop_front());
            end else begin
                chk("idle_idx", longint'(out_grp_idx), 0);
                chk("idle_last", longint'(out_last), 0);
            end
            ev = (done_q.size() > 0) && (done_q[0] == cyc);
            chk("done", longint'(done), longint'(ev));
            if (ev) void'(done_q.pop_front());
            ev = (err_q.size() > 0) && (err_q[0] == cyc);
            chk("err_start", longint'(err_start), longint'(ev));
            if (ev) void'(err_q.pop_front());
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        clk   = 0;
        rst_n = 0;
        start = 0;
        num_grp   = '0;
        base_addr = '0;
        src_avail = 0;
        model_reset();
        #12;
        chk_all_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1;

        run_job(4, 'h10, 16'hFFFF, 16, 100, 0, 0);
        repeat (3) step(0, 0, 0, 0);
        run_job(3, 'h40, 16'b11001, 5, 100, 0, 0);
        run_job(4, 'h3FE, 16'hFFFF, 16, 100, 0, 0);
        run_job(0, 'h55, 16'h0, 0, 100, 0, 0);
        run_job(5, 'h20, 16'hFFFF, 16, 100, 0, 1);
        run_job(1, 'h3FF, 16'h0, 3, 100, 0, 0);
        for (int i = 0; i < 25; i++) begin
            run_job(int'($urandom_range(9)), int'($urandom_range(1023)), 16'h0, 0, 60, 10, 0);
            repeat (int'($urandom_range(2))) step(0, 0, 0, int'($urandom_range(1)) == 1);
        end

        // Abandon a long job mid-issue.
        step(1, 30, 'h100, 0);
        repeat (10) step(0, 0, 0, 1);
        start = 0;
        src_avail = 0;
        rst_n = 0;
        #1;
        chk_all_zero("midrst");
        model_reset();
        repeat (3) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        rst_n = 1;
        repeat (40) step(0, 0, 0, 0);
        run_job(4, 'h10, 16'hFFFF, 16, 100, 0, 0);

        repeat (30) step(0, 0, 0, 0);
        chk("pending_out", longint'(out_q.size()), 0);
        chk("pending_done", longint'(done_q.size()), 0);
        chk("pending_err", longint'(err_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
